// File: rtl/cnn_pkg.sv
// Shared widths, FSM encodings and tap/window geometry for the 3x3 convolution MAC.
package cnn_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int W_W_DEF   = 8;
  localparam int ACC_W_DEF = 20;

  localparam int TAPS  = 9;
  localparam int ROWS  = 3;
  localparam int COLS  = 3;
  localparam int TAP_W = 4;

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_MAC     = 2'd2,
    ST_OUT     = 2'd3
  } state_e;

endpackage

// File: rtl/mac_unit.sv
// One unsigned-pixel x signed-weight multiply folded into a signed accumulator, purely combinational.
module mac_unit #(
  parameter int PIX_W = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = 20
) (
  input  logic        [PIX_W-1:0] pix_i,
  input  logic signed [W_W-1:0]   w_i,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] acc_o
);

  localparam int PROD_W = PIX_W + 1 + W_W;

  logic signed [PROD_W-1:0] pix_ext;
  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] prod;

  // pixel is zero-extended so it stays non-negative in the signed product
  assign pix_ext = {{(PROD_W-PIX_W){1'b0}}, pix_i};
  assign w_ext   = {{(PROD_W-W_W){w_i[W_W-1]}}, w_i};
  assign prod    = pix_ext * w_ext;
  assign acc_o   = acc_i + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

endmodule

// File: rtl/conv3x3_mac.sv
// Collects three packed pixel rows into a 3x3 window and runs a serial 9-tap signed MAC
// against a static kernel, emitting one (optionally ReLU-clamped) result per window.
module conv3x3_mac
  import cnn_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter bit RELU  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [COLS*PIX_W-1:0]   p,
  input  logic                    buffer_done,
  input  logic [TAPS*W_W-1:0]     kernel,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  state_e state_q, state_d;

  logic [1:0]                row_cnt_q;
  logic [TAP_W-1:0]          tap_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [COLS*PIX_W-1:0]     row0_q, row1_q, row2_q;
  logic signed [ACC_W-1:0]   out_sum_q;
  logic                      out_valid_q;
  logic                      overrun_q;

  logic [TAPS*PIX_W-1:0]     window;
  logic [PIX_W-1:0]          pix_sel;
  logic signed [W_W-1:0]     w_sel;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   out_sum_d;

  // tap i = 3*row + col lines up with row0 in the low bits of the flattened window
  assign window  = {row2_q, row1_q, row0_q};
  assign pix_sel = window[tap_q*PIX_W +: PIX_W];
  assign w_sel   = kernel[tap_q*W_W +: W_W];

  mac_unit #(.PIX_W(PIX_W), .W_W(W_W), .ACC_W(ACC_W)) u_mac (
    .pix_i (pix_sel),
    .w_i   (w_sel),
    .acc_i (acc_q),
    .acc_o (acc_next)
  );

  assign out_sum_d = (RELU && acc_q[ACC_W-1]) ? '0 : acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (buffer_done) state_d = ST_COLLECT;
        ST_COLLECT: if (buffer_done && row_cnt_q == 2'd2) state_d = ST_MAC;
        ST_MAC:     if (tap_q == LAST_TAP) state_d = ST_OUT;
        ST_OUT:     state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == ST_MAC) || (state_q == ST_OUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt_q   <= 2'd0;
      tap_q       <= '0;
      acc_q       <= '0;
      row0_q      <= '0;
      row1_q      <= '0;
      row2_q      <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (frame_start) begin
        row_cnt_q <= 2'd0;
        tap_q     <= '0;
        acc_q     <= '0;
      end else begin
        if (busy && buffer_done) overrun_q <= 1'b1;
        case (state_q)
          ST_IDLE: begin
            if (buffer_done) begin
              row0_q    <= p;
              row_cnt_q <= 2'd1;
            end
          end
          ST_COLLECT: begin
            if (buffer_done) begin
              if (row_cnt_q == 2'd1) row1_q <= p;
              else                   row2_q <= p;
              if (row_cnt_q == 2'd2) begin
                row_cnt_q <= 2'd0;
                tap_q     <= '0;
                acc_q     <= '0;
              end else begin
                row_cnt_q <= row_cnt_q + 2'd1;
              end
            end
          end
          ST_MAC: begin
            acc_q <= acc_next;
            if (tap_q != LAST_TAP) tap_q <= tap_q + 1'b1;
          end
          ST_OUT: begin
            out_sum_q   <= out_sum_d;
            out_valid_q <= 1'b1;
            tap_q       <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_sum   = out_sum_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_conv3x3_mac.sv
// Randomized self-checking bench for conv3x3_mac with a plain-arithmetic convolution model.
module tb_conv3x3_mac;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic [23:0]       p;
  logic              buffer_done;
  logic [71:0]       kernel;

  logic signed [19:0] sum0, sum1;
  logic               valid0, valid1, busy0, busy1, ovr0, ovr1;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_ovr  = 0;

  always #5 clk = ~clk;

  conv3x3_mac #(.RELU(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .p(p), .buffer_done(buffer_done),
    .kernel(kernel), .out_sum(sum0), .out_valid(valid0), .busy(busy0), .overrun(ovr0)
  );

  conv3x3_mac #(.RELU(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .p(p), .buffer_done(buffer_done),
    .kernel(kernel), .out_sum(sum1), .out_valid(valid1), .busy(busy1), .overrun(ovr1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int conv_ref(input logic [23:0] r0, input logic [23:0] r1,
                                  input logic [23:0] r2, input logic [71:0] k, input bit relu);
    logic [23:0] rows [3];
    int s;
    rows[0] = r0; rows[1] = r1; rows[2] = r2;
    s = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        int pv, wv;
        logic [7:0] pb;
        logic signed [7:0] wb;
        pb = rows[r][c*8 +: 8];
        wb = $signed(k[(3*r+c)*8 +: 8]);
        pv = pb;
        wv = wb;
        s += pv * wv;
      end
    end
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  task automatic send_row(input logic [23:0] r);
    p = r;
    buffer_done = 1'b1;
    @(negedge clk);
    buffer_done = 1'b0;
  endtask

  // Feeds one window and waits for its result; inject_at>0 pulses an extra row that many
  // cycles after the third row was sampled.
  task automatic run_window(input logic [23:0] r0, input logic [23:0] r1, input logic [23:0] r2,
                            input logic [71:0] k, input int gap, input int inject_at,
                            input string tag);
    int n;
    kernel = k;
    send_row(r0);
    repeat (gap) @(negedge clk);
    send_row(r1);
    repeat (gap) @(negedge clk);
    send_row(r2);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      buffer_done = 1'b0;
      if (i == 5) chk({tag, ":busy_mid"}, busy0, 1);
      if (i == inject_at) begin
        p = $urandom();
        buffer_done = 1'b1;
        exp_ovr = 1'b1;
      end
      if (valid0) begin
        n = i;
        break;
      end
    end
    buffer_done = 1'b0;
    chk({tag, ":latency"}, n, 10);
    chk({tag, ":sum"}, sum0, conv_ref(r0, r1, r2, k, 1'b0));
    chk({tag, ":sum_relu"}, sum1, conv_ref(r0, r1, r2, k, 1'b1));
    chk({tag, ":valid_relu"}, valid1, 1);
    @(negedge clk);
    chk({tag, ":valid_drop"}, valid0, 0);
    chk({tag, ":busy_end"}, busy0, 0);
    chk({tag, ":overrun"}, ovr0, int'(exp_ovr));
  endtask

  function automatic logic [71:0] rand_kernel();
    logic [71:0] k;
    for (int i = 0; i < 9; i++) k[i*8 +: 8] = 8'($urandom());
    return k;
  endfunction

  initial begin
    logic [71:0] k_ones, k_neg, k_ctr;
    int vcount;
    k_ones = {9{8'h01}};
    k_neg  = {9{8'h80}};
    k_ctr  = 72'h0;
    k_ctr[32 +: 8] = 8'h01;

    rst = 1'b0; frame_start = 1'b0; p = '0; buffer_done = 1'b0; kernel = '0;
    repeat (3) @(negedge clk);
    chk("rst:sum", sum0, 0);
    chk("rst:valid", valid0, 0);
    chk("rst:busy", busy0, 0);
    chk("rst:overrun", ovr0, 0);
    rst = 1'b1;
    @(negedge clk);

    run_window(24'h010101, 24'h010101, 24'h010101, k_ones, 0, 0, "ones");
    run_window(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, k_neg, 0, 0, "minneg");
    chk("minneg:abs", sum0, -293760);
    chk("minneg:relu0", sum1, 0);
    run_window(24'h030201, 24'h060504, 24'h090807, k_ctr, 1, 0, "centre");
    chk("centre:abs", sum0, 5);

    for (int t = 0; t < 8; t++)
      run_window($urandom(), $urandom(), $urandom(), rand_kernel(), $urandom_range(0, 2), 0, "rand");

    run_window($urandom(), $urandom(), $urandom(), rand_kernel(), 0, 4, "ovr_mac");
    run_window($urandom(), $urandom(), $urandom(), rand_kernel(), 1, 0, "after_ovr");
    run_window($urandom(), $urandom(), $urandom(), rand_kernel(), 0, 9, "ovr_out");

    // reset in the middle of the MAC
    kernel = k_ones;
    send_row(24'h123456); send_row(24'h654321); send_row(24'hABCDEF);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst:sum", sum0, 0);
    chk("midrst:valid", valid0, 0);
    chk("midrst:busy", busy0, 0);
    chk("midrst:overrun", ovr0, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_ovr = 1'b0;
    @(negedge clk);
    run_window(24'h010101, 24'h010101, 24'h010101, k_ones, 0, 0, "postrst");
    chk("postrst:abs", sum0, 9);

    // partial window discarded by frame_start
    send_row(24'h7F7F7F);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    run_window(24'h030201, 24'h060504, 24'h090807, k_ctr, 0, 0, "fs_partial");
    chk("fs_partial:abs", sum0, 5);

    // frame_start with a coincident row mid-MAC: no result, no overrun
    kernel = rand_kernel();
    send_row($urandom()); send_row($urandom()); send_row($urandom());
    repeat (2) @(negedge clk);
    frame_start = 1'b1;
    buffer_done = 1'b1;
    p = $urandom();
    @(negedge clk);
    frame_start = 1'b0;
    buffer_done = 1'b0;
    vcount = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (valid0) vcount++;
    end
    chk("fs_mac:no_valid", vcount, 0);
    chk("fs_mac:overrun", ovr0, 0);
    chk("fs_mac:busy", busy0, 0);
    chk("fs_mac:sum_kept", sum0, 5);
    run_window($urandom(), $urandom(), $urandom(), rand_kernel(), 0, 0, "after_fs");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
